seq_divider_param: RTL and testbench

Parametrised multi-cycle restoring divider for the matching datapath. It replaces the fixed 16-bit unsigned divider with a configurable WIDTH, signed and unsigned modes, and a start/ready handshake. It also flags divide-by-zero and signed overflow, and holds its results stable between operations. It sits between the feature-score accumulators and the normalisation stage: one request in, one quotient/remainder pair out.

---
 rtl/seq_divider_param.sv | 220 ++++++++++++++++++++++
 tb/tb_seq_divider_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_param.sv
// seq_divider_param
//   Multi-cycle restoring divider with a configurable operand width, signed
//   and unsigned modes and a start/ready handshake. One restoring step is
//   performed per clock; results are held stable until the next operation
//   completes.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        request strobe, sampled only while ready=1
//   signed_mode  1 = two's-complement operands, 0 = unsigned (captured with start)
//   dividend     numerator   (captured with start)
//   divisor      denominator (captured with start)
//   ready        high while idle and able to accept a request
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done
//   div_by_zero  divisor was zero for the last result
//   overflow     last result was signed MIN / -1

module seq_divider_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;           // partial remainder
  logic [WIDTH-1:0]   dq_q, dq_d;             // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;         // divisor magnitude
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               ovf_q, ovf_d;           // pending overflow flag for this operation
  logic               dz_q, dz_d;             // pending divide-by-zero flag
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_by_zero_q, div_by_zero_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  // Operand preparation at the accept edge
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero_in;

  // One restoring step: the shifted remainder needs one extra bit
  logic [WIDTH:0]     shifted;
  logic               fits;

  assign a_neg       = signed_mode & dividend[WIDTH-1];
  assign b_neg       = signed_mode & divisor[WIDTH-1];
  // |MIN| wraps back to MIN, which read as unsigned is exactly 2^(WIDTH-1)
  assign a_mag       = a_neg ? (~dividend + 1'b1) : dividend;
  assign b_mag       = b_neg ? (~divisor + 1'b1) : divisor;
  assign div_zero_in = (divisor == '0);

  assign shifted = {rem_q, dq_q[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvsr_q});

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = div_zero_in ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        // Last step is the one that consumes count==1
        if (count_q == CNT_W'(1)) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    ready  = (state_q == S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    count_d       = count_q;
    rem_d         = rem_q;
    dq_d          = dq_q;
    dvsr_d        = dvsr_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    ovf_d         = ovf_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (div_zero_in) begin
            // Zero-divide result is fixed regardless of mode
            dq_d      = '1;
            rem_d     = dividend;
            dvsr_d    = '0;
            count_d   = '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            ovf_d     = 1'b0;
            dz_d      = 1'b1;
          end else begin
            dq_d      = a_mag;
            rem_d     = '0;
            dvsr_d    = b_mag;
            count_d   = CNT_INIT;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            ovf_d     = signed_mode & (dividend == MIN_VAL) & (divisor == '1);
            dz_d      = 1'b0;
          end
        end
      end
      S_CALC: begin
        // Shifted remainder minus divisor is below the divisor, so the low
        // WIDTH bits of the difference are exact.
        rem_d   = fits ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];
        dq_d    = {dq_q[WIDTH-2:0], fits};
        count_d = count_q - 1'b1;
      end
      S_FIXUP: begin
        // Truncation toward zero: remainder follows the dividend's sign.
        // MIN / -1 leaves magnitude 2^(WIDTH-1) un-negated, i.e. MIN.
        if (neg_quo_q) dq_d  = ~dq_q + 1'b1;
        if (neg_rem_q) rem_d = ~rem_q + 1'b1;
      end
      S_DONE: begin
        quotient_d    = dq_q;
        remainder_d   = rem_q;
        div_by_zero_d = dz_q;
        overflow_d    = ovf_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      rem_q         <= '0;
      dq_q          <= '0;
      dvsr_q        <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      ovf_q         <= 1'b0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      rem_q         <= rem_d;
      dq_q          <= dq_d;
      dvsr_q        <= dvsr_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      ovf_q         <= ovf_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Testbench for seq_divider_param: three instances (WIDTH 8, 16, 32) driven
// with directed and randomized requests, each checked every cycle against an
// arithmetic reference model, plus literal expectations for known cases.

module tb_seq_divider_param;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } res_t;

  logic              clk;
  logic              reset;
  logic [2:0]        start_i;
  logic              sm_i;
  logic [31:0]       a_i, b_i;
  logic [2:0]        ready_o, done_o, dz_o, ov_o;
  logic [2:0][31:0]  q_o, r_o;
  bit                armed;

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 8 : (k == 1) ? 16 : 32;
  endfunction

  // Reference: plain integer division with C-style truncation on sign-extended values
  function automatic res_t ref_fn(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b);
    res_t   res;
    longint mask, sa, sb, qq, rr;
    mask = (longint'(1) << w) - 1;
    res  = '0;
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    if (sb == 0) begin
      res.q  = 32'(mask);
      res.r  = 32'(sa);
      res.dz = 1'b1;
      return res;
    end
    if (sm) begin
      if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
    end
    qq     = sa / sb;
    rr     = sa % sb;
    res.q  = 32'(qq & mask);
    res.r  = 32'(rr & mask);
    res.ov = sm && (sa == -(longint'(1) << (w - 1))) && (sb == -1);
    return res;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 16 : 32;
    logic [W-1:0] q_w, r_w;
    logic         rdy_w, done_w, dz_w, ov_w;

    seq_divider_param #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_i[gi]),
      .signed_mode (sm_i),
      .dividend    (a_i[W-1:0]),
      .divisor     (b_i[W-1:0]),
      .ready       (rdy_w),
      .done        (done_w),
      .quotient    (q_w),
      .remainder   (r_w),
      .div_by_zero (dz_w),
      .overflow    (ov_w)
    );

    assign q_o[gi]     = 32'(q_w);
    assign r_o[gi]     = 32'(r_w);
    assign ready_o[gi] = rdy_w;
    assign done_o[gi]  = done_w;
    assign dz_o[gi]    = dz_w;
    assign ov_o[gi]    = ov_w;

    // Transaction-level model: accept when idle, deliver after a fixed latency
    logic        m_busy, m_done, m_dz, m_ov;
    logic [31:0] m_q, m_r;
    int          m_left;
    res_t        p;

    initial begin
      m_busy = 0; m_done = 0; m_dz = 0; m_ov = 0; m_q = 0; m_r = 0; m_left = 0; p = '0;
      forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
          m_busy = 0; m_done = 0; m_dz = 0; m_ov = 0; m_q = 0; m_r = 0; m_left = 0;
        end else begin
          m_done = 0;
          if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
              m_busy = 0; m_done = 1;
              m_q = p.q; m_r = p.r; m_dz = p.dz; m_ov = p.ov;
            end
          end else if (start_i[gi]) begin
            p      = ref_fn(W, sm_i, a_i, b_i);
            m_busy = 1;
            m_left = p.dz ? 1 : W + 2;
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (armed) begin
          chk($sformatf("w%0d_ready", W), 64'(rdy_w), 64'(!m_busy));
          chk($sformatf("w%0d_done", W), 64'(done_w), 64'(m_done));
          chk($sformatf("w%0d_quotient", W), 64'(q_w), 64'(m_q));
          chk($sformatf("w%0d_remainder", W), 64'(r_w), 64'(m_r));
          chk($sformatf("w%0d_div_by_zero", W), 64'(dz_w), 64'(m_dz));
          chk($sformatf("w%0d_overflow", W), 64'(ov_w), 64'(m_ov));
        end
      end
    end
  end

  // Issue one request on instance k and wait for its done pulse. Called at a negedge.
  task automatic run_op(input int k, input logic sm, input logic [31:0] a, input logic [31:0] b,
                        input bit lit, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eov, input int elat, input bit junk);
    int n;
    bit seen;
    n = 0;
    while (ready_o[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("w%0d_ready_before_start", wid(k)), 64'(ready_o[k]), 64'd1);
    sm_i = sm; a_i = a; b_i = b; start_i[k] = 1'b1;
    @(posedge clk);
    #1;
    start_i[k] = 1'b0;
    sm_i = 1'($urandom); a_i = $urandom; b_i = $urandom;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done_o[k] === 1'b1) seen = 1;
      else if (junk && n == 2) begin
        sm_i = 1'b0; a_i = 32'd9; b_i = 32'd3; start_i[k] = 1'b1;
      end else if (n == 3) start_i[k] = 1'b0;
    end
    start_i[k] = 1'b0;
    chk($sformatf("w%0d_done_seen", wid(k)), 64'(seen), 64'd1);
    if (lit) begin
      chk($sformatf("w%0d_latency", wid(k)), 64'(n), 64'(elat));
      chk($sformatf("w%0d_lit_q", wid(k)), 64'(q_o[k]), 64'(eq));
      chk($sformatf("w%0d_lit_r", wid(k)), 64'(r_o[k]), 64'(er));
      chk($sformatf("w%0d_lit_dz", wid(k)), 64'(dz_o[k]), 64'(edz));
      chk($sformatf("w%0d_lit_ov", wid(k)), 64'(ov_o[k]), 64'(eov));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        pin;
    int          k, w;
    logic [31:0] mask, minv, a, b;
    bit          seen;

    reset = 1'b1; start_i = '0; sm_i = 1'b0; a_i = '0; b_i = '0; armed = 0;
    #2;
    reset = 1'b0;
    armed = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", 64'(ready_o[i]), 64'd1);
      chk("reset_done", 64'(done_o[i]), 64'd0);
      chk("reset_q", 64'(q_o[i]), 64'd0);
      chk("reset_r", 64'(r_o[i]), 64'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Pin the model on hand-computed values
    pin = ref_fn(16, 1'b1, 32'hFF9C, 32'h0007);
    chk("model_neg100_div7_q", 64'(pin.q), 64'hFFF2);
    chk("model_neg100_div7_r", 64'(pin.r), 64'hFFFE);
    pin = ref_fn(16, 1'b1, 32'h8000, 32'hFFFF);
    chk("model_min_div_m1_ov", 64'({pin.q, pin.ov}), 64'h1_0001);
    pin = ref_fn(8, 1'b0, 32'd100, 32'd0);
    chk("model_div0", 64'({pin.q, pin.r, pin.dz}), 64'({32'hFF, 32'd100, 1'b1}));

    @(negedge clk);
    // WIDTH=16 directed
    run_op(1, 1'b0, 32'd100,  32'd7,     1, 32'd14,    32'd2,    0, 0, 18, 0);
    run_op(1, 1'b1, 32'hFF9C, 32'h0007,  1, 32'hFFF2,  32'hFFFE, 0, 0, 18, 0);
    run_op(1, 1'b1, 32'd100,  32'hFFF9,  1, 32'hFFF2,  32'h0002, 0, 0, 18, 0);
    run_op(1, 1'b1, 32'h8000, 32'hFFFF,  1, 32'h8000,  32'h0,    0, 1, 18, 0);
    run_op(1, 1'b0, 32'h8000, 32'hFFFF,  1, 32'h0,     32'h8000, 0, 0, 18, 0);
    run_op(1, 1'b0, 32'h1234, 32'h0,     1, 32'hFFFF,  32'h1234, 1, 0, 1,  0);
    run_op(1, 1'b1, 32'h1234, 32'h0,     1, 32'hFFFF,  32'h1234, 1, 0, 1,  0);
    run_op(1, 1'b0, 32'd100,  32'd7,     1, 32'd14,    32'd2,    0, 0, 18, 0);
    run_op(1, 1'b0, 32'd50000, 32'd3,    1, 32'd16666, 32'd2,    0, 0, 18, 1);
    run_op(1, 1'b0, 32'd9,    32'd3,     1, 32'd3,     32'd0,    0, 0, 18, 0);
    // WIDTH=8 directed
    run_op(0, 1'b0, 32'd100,  32'd7,     1, 32'd14,    32'd2,    0, 0, 10, 0);
    run_op(0, 1'b1, 32'h9C,   32'h07,    1, 32'hF2,    32'hFE,   0, 0, 10, 0);
    run_op(0, 1'b1, 32'h80,   32'hFF,    1, 32'h80,    32'h0,    0, 1, 10, 0);
    run_op(0, 1'b0, 32'h80,   32'hFF,    1, 32'h0,     32'h80,   0, 0, 10, 0);
    run_op(0, 1'b1, 32'h9C,   32'h0,     1, 32'hFF,    32'h9C,   1, 0, 1,  0);
    // WIDTH=32 directed
    run_op(2, 1'b0, 32'd100,       32'd7,         1, 32'd14,        32'd2,        0, 0, 34, 0);
    run_op(2, 1'b1, 32'hFFFFFF9C,  32'd7,         1, 32'hFFFFFFF2,  32'hFFFFFFFE, 0, 0, 34, 0);
    run_op(2, 1'b1, 32'd100,       32'hFFFFFFF9,  1, 32'hFFFFFFF2,  32'd2,        0, 0, 34, 0);
    run_op(2, 1'b1, 32'h80000000,  32'hFFFFFFFF,  1, 32'h80000000,  32'd0,        0, 1, 34, 0);
    run_op(2, 1'b0, 32'h80000000,  32'hFFFFFFFF,  1, 32'd0,         32'h80000000, 0, 0, 34, 0);

    // Randomized, back-to-back requests
    for (int t = 0; t < 150; t++) begin
      k    = $urandom_range(0, 2);
      w    = wid(k);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      minv = 32'h1 << (w - 1);
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = mask;
        2:       b = 32'($urandom_range(1, 5));
        3:       b = mask - 32'($urandom_range(0, 3));
        default: b = $urandom & mask;
      endcase
      case ($urandom_range(0, 5))
        0:       a = minv;
        1:       a = 32'h0;
        default: a = $urandom & mask;
      endcase
      run_op(k, 1'($urandom), a, b, 0, 32'h0, 32'h0, 0, 0, 0, ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a calculation
    @(negedge clk);
    sm_i = 1'b0; a_i = 32'd50000; b_i = 32'd3; start_i = 3'b110;
    @(posedge clk);
    #1;
    start_i = '0;
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midreset_ready", 64'(ready_o[i]), 64'd1);
      chk("midreset_done", 64'(done_o[i]), 64'd0);
      chk("midreset_q", 64'(q_o[i]), 64'd0);
      chk("midreset_r", 64'(r_o[i]), 64'd0);
      chk("midreset_flags", 64'({dz_o[i], ov_o[i]}), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o != 3'b000) seen = 1;
    end
    chk("no_done_after_reset", 64'(seen), 64'd0);
    run_op(2, 1'b1, 32'hFFFFFF9C, 32'd7, 1, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0, 34, 0);
    run_op(1, 1'b1, 32'hFF9C, 32'h0007, 1, 32'hFFF2, 32'hFFFE, 0, 0, 18, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
